// File: rtl/fusion_pe.sv
// BitFusion processing element: packed 2/4/8-bit dot product per beat, accumulated over a
// first..last sequence, with a registered input forward path and a valid/ready psum output.
module fusion_pe #(
   parameter int LANES    = 4,
   parameter int ACC_W    = 32,
   parameter bit SATURATE = 1
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic [2:0]           cfg_input_bw,
   input  logic [2:0]           cfg_weight_bw,
   input  logic                 cfg_input_signed,
   input  logic                 cfg_weight_signed,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [LANES*8-1:0]   input_forward,
   input  logic [LANES*8-1:0]   weight,
   output logic [LANES*8-1:0]   input_to_right,
   output logic                 fwd_valid,
   output logic [ACC_W-1:0]     psum,
   output logic                 psum_valid,
   input  logic                 psum_ready,
   output logic                 sat_flag
);

   localparam int NMAX  = LANES * 4;
   localparam int P_W   = 19 + $clog2(NMAX);
   localparam int SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

   localparam logic [NMAX-1:0] MASK2 = {NMAX{1'b1}};
   localparam logic [NMAX-1:0] MASK4 = {{(NMAX-2*LANES){1'b0}}, {(2*LANES){1'b1}}};
   localparam logic [NMAX-1:0] MASK8 = {{(3*LANES){1'b0}}, {LANES{1'b1}}};

   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                    ready_reg;
   logic                    en;
   logic                    accept;
   logic [1:0]              in_mode;
   logic [1:0]              w_mode;
   logic [NMAX-1:0]         pair_mask;
   logic signed [17:0]      lane_prod [NMAX];
   logic signed [P_W-1:0]   beat_sum;

   logic                    s1_valid;
   logic                    s1_first;
   logic                    s1_last;
   logic signed [P_W-1:0]   p_reg;

   logic signed [ACC_W-1:0] acc_reg;
   logic                    sat_run_reg;
   logic signed [ACC_W-1:0] acc_base;
   logic signed [SUM_W-1:0] sum_full;
   logic                    fits;
   logic                    sat_hit;
   logic signed [ACC_W-1:0] acc_result;
   logic                    sat_new;

   // mode 0: 2b, 1: 4b, 2: 8b (anything not one-hot falls back to 8b)
   function automatic logic [1:0] decode_bw(input logic [2:0] bw);
      case (bw)
         3'b001:  decode_bw = 2'd0;
         3'b010:  decode_bw = 2'd1;
         default: decode_bw = 2'd2;
      endcase
   endfunction

   function automatic logic [NMAX-1:0] mode_mask(input logic [1:0] mode);
      case (mode)
         2'd0:    mode_mask = MASK2;
         2'd1:    mode_mask = MASK4;
         default: mode_mask = MASK8;
      endcase
   endfunction

   function automatic logic signed [8:0] elem(input logic [1:0] mode, input logic sgn,
                                              input logic [1:0] e2, input logic [3:0] e4,
                                              input logic [7:0] e8);
      case (mode)
         2'd0:    elem = {{7{sgn & e2[1]}}, e2};
         2'd1:    elem = {{5{sgn & e4[3]}}, e4};
         default: elem = {sgn & e8[7], e8};
      endcase
   endfunction

   assign en       = !psum_valid || psum_ready;
   assign in_ready = ready_reg && en;
   assign accept   = in_valid && in_ready;

   always_comb begin
      in_mode   = decode_bw(cfg_input_bw);
      w_mode    = decode_bw(cfg_weight_bw);
      pair_mask = mode_mask(in_mode) & mode_mask(w_mode);
   end

   for (genvar gi = 0; gi < NMAX; gi++) begin : g_lane
      logic [1:0]        x2;
      logic [1:0]        w2;
      logic [3:0]        x4;
      logic [3:0]        w4;
      logic [7:0]        x8;
      logic [7:0]        w8;
      logic signed [8:0] x_elem;
      logic signed [8:0] w_elem;

      assign x2 = input_forward[2*gi +: 2];
      assign w2 = weight[2*gi +: 2];
      if (gi < 2*LANES) begin : g_n4
         assign x4 = input_forward[4*gi +: 4];
         assign w4 = weight[4*gi +: 4];
      end else begin : g_z4
         assign x4 = '0;
         assign w4 = '0;
      end
      if (gi < LANES) begin : g_n8
         assign x8 = input_forward[8*gi +: 8];
         assign w8 = weight[8*gi +: 8];
      end else begin : g_z8
         assign x8 = '0;
         assign w8 = '0;
      end

      assign x_elem        = elem(in_mode, cfg_input_signed, x2, x4, x8);
      assign w_elem        = elem(w_mode, cfg_weight_signed, w2, w4, w8);
      assign lane_prod[gi] = pair_mask[gi] ? x_elem * w_elem : 18'sd0;
   end

   always_comb begin
      beat_sum = '0;
      for (int k = 0; k < NMAX; k++) begin
         beat_sum = beat_sum + P_W'(lane_prod[k]);
      end
   end

   // The sum is formed one bit wider than both operands so the clamp decision is exact.
   always_comb begin
      acc_base   = s1_first ? '0 : acc_reg;
      sum_full   = SUM_W'(acc_base) + SUM_W'(p_reg);
      fits       = (sum_full[SUM_W-1:ACC_W-1] == '0) || (sum_full[SUM_W-1:ACC_W-1] == '1);
      sat_hit    = SATURATE && !fits;
      if (sat_hit) begin
         acc_result = sum_full[SUM_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
         acc_result = sum_full[ACC_W-1:0];
      end
      sat_new    = (s1_first ? 1'b0 : sat_run_reg) | sat_hit;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ready_reg      <= 1'b0;
         s1_valid       <= 1'b0;
         s1_first       <= 1'b0;
         s1_last        <= 1'b0;
         p_reg          <= '0;
         input_to_right <= '0;
         fwd_valid      <= 1'b0;
      end else begin
         ready_reg <= 1'b1;
         if (en) begin
            s1_valid  <= accept;
            fwd_valid <= accept;
            if (accept) begin
               p_reg          <= beat_sum;
               s1_first       <= in_first;
               s1_last        <= in_last;
               input_to_right <= input_forward;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         acc_reg     <= '0;
         sat_run_reg <= 1'b0;
         psum        <= '0;
         psum_valid  <= 1'b0;
         sat_flag    <= 1'b0;
      end else if (en) begin
         psum_valid <= s1_valid && s1_last;
         if (s1_valid) begin
            if (s1_last) begin
               psum        <= acc_result;
               sat_flag    <= sat_new;
               acc_reg     <= '0;
               sat_run_reg <= 1'b0;
            end else begin
               acc_reg     <= acc_result;
               sat_run_reg <= sat_new;
            end
         end
      end
   end

endmodule
